// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage of a 5-stage RV32I pipeline. Owns the PC, presents
//   it to instruction memory and captures the returned word into the IF/ID
//   pipeline register. Supports a load-use stall from the hazard unit and a
//   branch/jump redirect from EX, which squashes the wrong-path fetch by
//   inserting one bubble. Also keeps a delivered-instruction counter and a
//   sticky flag for redirect targets that are not word aligned.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   stall               hold PC and IF/ID
//   redirect            taken branch/jump; overrides stall, flushes IF/ID
//   redirect_target     new PC (low two bits forced to zero)
//   imem_addr           instruction-memory address (= PC register)
//   imem_rdata          instruction word, combinational read of imem_addr
//   id_pc, id_pc_plus4  PC (and PC+4 link value) of the IF/ID instruction
//   id_instr, id_valid  IF/ID instruction and real-vs-bubble qualifier
//   misalign_err        sticky: a redirect target had [1:0] != 0
//   fetch_count         instructions delivered into IF/ID (wraps)
// ----------------------------------------------------------------------------
module if_fetch_stage #(
    parameter int unsigned       XLEN      = 32,
    parameter logic [XLEN-1:0]   RESET_PC  = '0,
    parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    output logic [31:0]     id_instr,
    output logic            id_valid,
    output logic            misalign_err,
    output logic [31:0]     fetch_count
);

    localparam int unsigned ILEN = 32;
    localparam int unsigned CNTW = 32;

    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    localparam logic [CNTW-1:0] CNT_STEP = CNTW'(1);

    // IF/ID pipeline register payload
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [ILEN-1:0] instr;
        logic            valid;
    } ifid_t;

    localparam ifid_t IFID_RESET = '{
        pc:       '0,
        pc_plus4: '0,
        instr:    NOP_INSTR,
        valid:    1'b0
    };

    // What the stage does on the coming edge (reset is handled in the flops)
    typedef enum logic [1:0] {
        ACT_ADVANCE  = 2'd0,
        ACT_STALL    = 2'd1,
        ACT_REDIRECT = 2'd2
    } fetch_act_e;

    fetch_act_e      act_c;

    logic [XLEN-1:0] pc_q, pc_d;
    ifid_t           ifid_q, ifid_d;
    logic            misalign_q, misalign_d;
    logic [CNTW-1:0] fetch_count_q, fetch_count_d;

    logic [XLEN-1:0] pc_inc_c;
    logic [XLEN-1:0] target_aligned_c;
    logic            target_misaligned_c;

    // Sequential-PC increment and redirect-target alignment
    always_comb begin
        pc_inc_c            = pc_q + PC_STEP;
        target_aligned_c    = {redirect_target[XLEN-1:2], 2'b00};
        target_misaligned_c = (redirect_target[1:0] != 2'b00);
    end

    // Edge action priority: redirect beats stall beats advance
    always_comb begin
        act_c = ACT_ADVANCE;
        if (redirect) begin
            act_c = ACT_REDIRECT;
        end else if (stall) begin
            act_c = ACT_STALL;
        end
    end

    // Next-state for PC, IF/ID, counter and sticky flag
    always_comb begin
        pc_d          = pc_q;
        ifid_d        = ifid_q;
        misalign_d    = misalign_q;
        fetch_count_d = fetch_count_q;

        case (act_c)
            ACT_ADVANCE: begin
                pc_d            = pc_inc_c;
                ifid_d.pc       = pc_q;
                ifid_d.pc_plus4 = pc_inc_c;
                ifid_d.instr    = imem_rdata;
                ifid_d.valid    = 1'b1;
                fetch_count_d   = fetch_count_q + CNT_STEP;
            end
            ACT_REDIRECT: begin
                // Wrong-path word is dropped; id_pc/id_pc_plus4 keep their
                // last value so only the bubble marking changes.
                pc_d         = target_aligned_c;
                ifid_d.instr = NOP_INSTR;
                ifid_d.valid = 1'b0;
                if (target_misaligned_c) begin
                    misalign_d = 1'b1;
                end
            end
            default: begin
                // ACT_STALL: everything holds
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            ifid_q        <= IFID_RESET;
            misalign_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            ifid_q        <= ifid_d;
            misalign_q    <= misalign_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Outputs straight from the registers
    assign imem_addr    = pc_q;
    assign id_pc        = ifid_q.pc;
    assign id_pc_plus4  = ifid_q.pc_plus4;
    assign id_instr     = ifid_q.instr;
    assign id_valid     = ifid_q.valid;
    assign misalign_err = misalign_q;
    assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_stage
//   Two instances (RESET_PC = 0 and RESET_PC = 0xFFFF_FFFC) share stall /
//   redirect / reset stimulus. Each has its own instruction memory returning
//   addr|1. A per-instance reference model applies the fetch rules each edge;
//   directed scenarios add constant checks, then a random phase follows.
// ----------------------------------------------------------------------------
module tb_if_fetch_stage;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] RP0      = 32'h0000_0000;
    localparam logic [31:0] RP1      = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;

    logic [31:0] imem_addr0, imem_rdata0, id_pc0, id_pc_plus40, id_instr0, fetch_count0;
    logic        id_valid0, misalign_err0;
    logic [31:0] imem_addr1, imem_rdata1, id_pc1, id_pc_plus41, id_instr1, fetch_count1;
    logic        id_valid1, misalign_err1;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model state, one entry per instance
    logic [31:0] m_pc    [2];
    logic [31:0] m_id_pc [2];
    logic [31:0] m_id_pc4[2];
    logic [31:0] m_instr [2];
    logic        m_valid [2];
    logic        m_mis   [2];
    logic [31:0] m_cnt   [2];

    always #5 clk = ~clk;

    assign imem_rdata0 = imem_addr0 | 32'h1;
    assign imem_rdata1 = imem_addr1 | 32'h1;

    if_fetch_stage u_dut0 (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr0),
        .imem_rdata      (imem_rdata0),
        .id_pc           (id_pc0),
        .id_pc_plus4     (id_pc_plus40),
        .id_instr        (id_instr0),
        .id_valid        (id_valid0),
        .misalign_err    (misalign_err0),
        .fetch_count     (fetch_count0)
    );

    if_fetch_stage #(.RESET_PC(RP1)) u_dut1 (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr1),
        .imem_rdata      (imem_rdata1),
        .id_pc           (id_pc1),
        .id_pc_plus4     (id_pc_plus41),
        .id_instr        (id_instr1),
        .id_valid        (id_valid1),
        .misalign_err    (misalign_err1),
        .fetch_count     (fetch_count1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_inst(input int idx,
                                input logic [31:0] addr, input logic [31:0] ipc,
                                input logic [31:0] ipc4, input logic [31:0] instr,
                                input logic valid, input logic mis, input logic [31:0] cnt);
        string p;
        p = (idx == 0) ? "dut0" : "dut1";
        check({p, ".imem_addr"},    addr,          m_pc[idx]);
        check({p, ".id_pc"},        ipc,           m_id_pc[idx]);
        check({p, ".id_pc_plus4"},  ipc4,          m_id_pc4[idx]);
        check({p, ".id_instr"},     instr,         m_instr[idx]);
        check({p, ".id_valid"},     32'(valid),    32'(m_valid[idx]));
        check({p, ".misalign_err"}, 32'(mis),      32'(m_mis[idx]));
        check({p, ".fetch_count"},  cnt,           m_cnt[idx]);
    endtask

    // Drive one edge worth of inputs, advance the model, then check at negedge
    task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] tgt);
        rst             = r;
        stall           = s;
        redirect        = rd;
        redirect_target = tgt;
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                m_pc[i]     = (i == 0) ? RP0 : RP1;
                m_id_pc[i]  = 32'h0;
                m_id_pc4[i] = 32'h0;
                m_instr[i]  = NOP;
                m_valid[i]  = 1'b0;
                m_mis[i]    = 1'b0;
                m_cnt[i]    = 32'h0;
            end else if (rd) begin
                m_pc[i]    = tgt - (tgt % 4);
                m_instr[i] = NOP;
                m_valid[i] = 1'b0;
                if ((tgt % 4) != 0) m_mis[i] = 1'b1;
            end else if (!s) begin
                m_id_pc[i]  = m_pc[i];
                m_id_pc4[i] = m_pc[i] + 32'd4;
                m_instr[i]  = m_pc[i] | 32'h1;
                m_valid[i]  = 1'b1;
                m_pc[i]     = m_pc[i] + 32'd4;
                m_cnt[i]    = m_cnt[i] + 32'd1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        compare_inst(0, imem_addr0, id_pc0, id_pc_plus40, id_instr0, id_valid0, misalign_err0, fetch_count0);
        compare_inst(1, imem_addr1, id_pc1, id_pc_plus41, id_instr1, id_valid1, misalign_err1, fetch_count1);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;

        // Reset for two edges
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("rst.imem_addr0", imem_addr0, 32'h0);
        check("rst.id_instr0",  id_instr0,  NOP);
        check("rst.imem_addr1", imem_addr1, 32'hFFFF_FFFC);

        // First fetch of the wrap instance: id_pc at top, link and PC wrap
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("wrap.id_pc1",       id_pc1,       32'hFFFF_FFFC);
        check("wrap.id_pc_plus41", id_pc_plus41, 32'h0);
        check("wrap.imem_addr1",   imem_addr1,   32'h0);
        check("adv1.id_pc0",       id_pc0,       32'h0);
        check("adv1.id_instr0",    id_instr0,    32'h1);

        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("adv2.id_pc0",     id_pc0,     32'h4);
        check("adv2.imem_addr0", imem_addr0, 32'h8);

        // Stall two edges with pc=8
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("stall.imem_addr0",   imem_addr0,   32'h8);
        check("stall.id_pc0",       id_pc0,       32'h4);
        check("stall.fetch_count0", fetch_count0, 32'd2);

        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("adv3.id_pc0",       id_pc0,       32'h8);
        check("adv3.fetch_count0", fetch_count0, 32'd3);
        check("adv3.id_valid0",    32'(id_valid0), 32'd1);

        // Redirect overriding stall
        step(1'b0, 1'b1, 1'b1, 32'h100);
        check("redir.imem_addr0", imem_addr0, 32'h100);
        check("redir.id_instr0",  id_instr0,  NOP);
        check("redir.id_valid0",  32'(id_valid0), 32'd0);
        check("redir.id_pc0",     id_pc0,     32'h8);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("redir.next_id_pc0", id_pc0, 32'h100);

        // Misaligned target: aligned PC, sticky flag until reset
        step(1'b0, 1'b0, 1'b1, 32'h102);
        check("mis.imem_addr0", imem_addr0, 32'h100);
        check("mis.flag0",      32'(misalign_err0), 32'd1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
        check("mis.held0", 32'(misalign_err0), 32'd1);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("mis.cleared0", 32'(misalign_err0), 32'd0);

        // Reset during stall with pc=0x40
        step(1'b0, 1'b0, 1'b1, 32'h40);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("rstst.pre_addr0", imem_addr0, 32'h40);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("rstst.imem_addr0",   imem_addr0,   32'h0);
        check("rstst.fetch_count0", fetch_count0, 32'h0);
        check("rstst.id_pc_plus40", id_pc_plus40, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            logic        r, s, rd;
            logic [31:0] tgt;
            r  = ($urandom_range(0, 59) == 0);
            s  = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 2))
                0:       tgt = $urandom & 32'hFFFF_FFFC;
                1:       tgt = $urandom;
                default: tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            endcase
            step(r, s, rd, tgt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
